// File: rtl/cpu_pkg.sv
// Shared opcode/state encodings and opcode-class helpers for the bit-serial core.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Encodings 0xD..0xF are unassigned and behave as NOP.
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_ST   = 4'h9,
        OP_LD   = 4'hA,
        OP_ADDR = 4'hB,
        OP_CMP  = 4'hC
    } opcode_t;

    // Opcodes whose commit updates flag_c / flag_z.
    function automatic logic updates_flags(input opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_ADDR, OP_CMP: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // Opcodes whose serial result replaces the accumulator.
    function automatic logic writes_acc(input opcode_t op);
        case (op)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_LD, OP_ADDR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Subtraction is acc + ~operand + 1, so the carry chain starts at 1.
    function automatic logic carry_seed(input opcode_t op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

    // Opcodes whose second operand comes from the register file.
    function automatic logic uses_reg_operand(input opcode_t op);
        return (op == OP_LD) || (op == OP_ADDR);
    endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit ALU slice: add/sub/logic/shift/pass on the current operand bits.
// Latency: result bit combinational, carry registered for the next bit.
// Backpressure: none; advances only when en is high.
module serial_alu_bit
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    init,
    input  logic    seed,
    input  logic    en,
    input  logic    a,
    input  logic    b,
    input  logic    prev_a,
    input  logic    next_a,
    input  opcode_t op,
    output logic    r,
    output logic    c
);

    logic bx;
    logic c_nxt;

    // Result bit and full-adder carry for the selected opcode.
    always_comb begin
        bx    = carry_seed(op) ? ~b : b;
        c_nxt = (a & bx) | (c & (a ^ bx));
        r     = 1'b0;
        case (op)
            OP_ADD, OP_ADDR, OP_SUB, OP_CMP: r = a ^ bx ^ c;
            OP_AND:                          r = a & b;
            OP_OR:                           r = a | b;
            OP_XOR:                          r = a ^ b;
            OP_SHL:                          r = prev_a;
            OP_SHR:                          r = next_a;
            OP_LDI, OP_LD:                   r = b;
            default:                         r = 1'b0;
        endcase
    end

    // Carry register: seeded at instruction start, ripples one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= 1'b0;
        end else if (init) begin
            c <= seed;
        end else if (en) begin
            c <= c_nxt;
        end
    end

endmodule

// File: rtl/bit_serial_exec.sv
// Bit-serial accumulator core: executes one loaded instruction LSB-first.
// Latency: 1 start edge + WIDTH bit cycles + 1 commit edge; busy for WIDTH+1 cycles.
// Backpressure: none; a start seen while busy is dropped, not queued.
module bit_serial_exec
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic [11:0]      instr,
    input  logic             inst_done,
    output logic [WIDTH-1:0] acc_bits,
    output logic             busy,
    output logic             flag_c,
    output logic             flag_z
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic             done_q;
    opcode_t          op_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             prev_a;
    logic [WIDTH-1:0] regs [NREGS];

    opcode_t          op_in;
    logic [WIDTH-1:0] imm_ext;
    logic             start;
    logic             seed_in;
    logic             alu_en;
    logic             alu_r;
    logic             alu_c;
    logic             unused_hi;

    assign op_in     = opcode_t'(opcode);
    assign imm_ext   = WIDTH'(instr[7:0]);
    assign start     = done_q & ~inst_done & (state == IDLE);
    assign seed_in   = carry_seed(op_in);
    assign alu_en    = (state == EXEC);
    assign unused_hi = ^instr[11:10];

    serial_alu_bit u_alu (
        .clk    (clk),
        .rst_n  (rst_n),
        .init   (start),
        .seed   (seed_in),
        .en     (alu_en),
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .prev_a (prev_a),
        .next_a (a_sh[1]),
        .op     (op_q),
        .r      (alu_r),
        .c      (alu_c)
    );

    // Loader handshake: a falling inst_done marks a complete instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= inst_done;
        end
    end

    // Sequencer and serial datapath: latch operands, shift one bit per EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            op_q   <= OP_NOP;
            sel_q  <= 2'd0;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            prev_a <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op_in;
                        sel_q  <= instr[9:8];
                        a_sh   <= acc_bits;
                        b_sh   <= uses_reg_operand(op_in) ? regs[instr[9:8]] : imm_ext;
                        cnt    <= '0;
                        prev_a <= 1'b0;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    prev_a <= a_sh[0];
                    res_sh <= {alu_r, res_sh[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Architectural commit: accumulator, flags and registers change only in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_bits <= '0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == DONE) begin
            if (writes_acc(op_q)) begin
                acc_bits <= res_sh;
            end
            if (op_q == OP_ST) begin
                regs[sel_q] <= acc_bits;
            end
            if (updates_flags(op_q)) begin
                flag_z <= ~|res_sh;
                case (op_q)
                    OP_ADD, OP_ADDR, OP_SUB, OP_CMP: flag_c <= alu_c;
                    OP_SHL:                          flag_c <= acc_bits[WIDTH-1];
                    OP_SHR:                          flag_c <= acc_bits[0];
                    default:                         flag_c <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_exec.sv
// Directed bench for bit_serial_exec: hand-computed vectors per feature.
// Latency: each instruction observed from start edge through commit.
// Backpressure: exercises dropped starts while busy.
module tb_bit_serial_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [11:0] instr = 12'h000;
    logic        inst_done = 1'b0;
    logic [7:0]  acc_bits;
    logic        busy;
    logic        flag_c;
    logic        flag_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_serial_exec #(.WIDTH(8), .NREGS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .instr     (instr),
        .inst_done (inst_done),
        .acc_bits  (acc_bits),
        .busy      (busy),
        .flag_c    (flag_c),
        .flag_z    (flag_z)
    );

    // Load one instruction, then follow it until busy drops (bounded).
    task automatic run_instr(input logic [3:0] op, input logic [7:0] imm, input logic [1:0] sel,
                             output int bcyc, output logic [7:0] acc_mid);
        @(negedge clk);
        opcode    = op;
        instr     = {2'b00, sel, imm};
        inst_done = 1'b1;
        @(negedge clk);
        inst_done = 1'b0;
        @(posedge clk);
        #1;
        bcyc    = 0;
        acc_mid = acc_bits;
        for (int i = 0; i < 30; i++) begin
            if (busy) begin
                bcyc++;
                if (bcyc == 5) acc_mid = acc_bits;
            end else if (bcyc > 0) begin
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (acc_bits !== 8'h00) begin bad++; $display("FAIL reset_acc got=%h want=00", acc_bits); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (flag_c !== 1'b0) begin bad++; $display("FAIL reset_c got=%b want=0", flag_c); end
        total++; if (flag_z !== 1'b0) begin bad++; $display("FAIL reset_z got=%b want=0", flag_z); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_no_start got=%b want=0", busy); end
    endtask

    task automatic test_ldi();
        int b; logic [7:0] m;
        run_instr(4'h1, 8'h5A, 2'd0, b, m);
        total++; if (acc_bits !== 8'h5A) begin bad++; $display("FAIL ldi_acc got=%h want=5a", acc_bits); end
        total++; if (flag_c !== 1'b0) begin bad++; $display("FAIL ldi_c got=%b want=0", flag_c); end
        total++; if (flag_z !== 1'b0) begin bad++; $display("FAIL ldi_z got=%b want=0", flag_z); end
        total++; if (b != 9) begin bad++; $display("FAIL ldi_busy_cycles got=%0d want=9", b); end
    endtask

    task automatic test_add_sub();
        int b; logic [7:0] m;
        run_instr(4'h2, 8'hC0, 2'd0, b, m);
        total++; if (m !== 8'h5A) begin bad++; $display("FAIL add_acc_stable got=%h want=5a", m); end
        total++; if (acc_bits !== 8'h1A) begin bad++; $display("FAIL add_acc got=%h want=1a", acc_bits); end
        total++; if (flag_c !== 1'b1) begin bad++; $display("FAIL add_c got=%b want=1", flag_c); end
        total++; if (flag_z !== 1'b0) begin bad++; $display("FAIL add_z got=%b want=0", flag_z); end
        run_instr(4'h3, 8'h1A, 2'd0, b, m);
        total++; if (acc_bits !== 8'h00) begin bad++; $display("FAIL sub_acc got=%h want=00", acc_bits); end
        total++; if (flag_c !== 1'b1) begin bad++; $display("FAIL sub_c got=%b want=1", flag_c); end
        total++; if (flag_z !== 1'b1) begin bad++; $display("FAIL sub_z got=%b want=1", flag_z); end
    endtask

    task automatic test_regs();
        int b; logic [7:0] m;
        run_instr(4'h1, 8'h3C, 2'd0, b, m);
        run_instr(4'h9, 8'h00, 2'd2, b, m);
        total++; if (acc_bits !== 8'h3C) begin bad++; $display("FAIL st_acc got=%h want=3c", acc_bits); end
        run_instr(4'h1, 8'h00, 2'd0, b, m);
        total++; if (acc_bits !== 8'h00) begin bad++; $display("FAIL ldi0_acc got=%h want=00", acc_bits); end
        run_instr(4'hA, 8'hFF, 2'd2, b, m);
        total++; if (acc_bits !== 8'h3C) begin bad++; $display("FAIL ld_acc got=%h want=3c", acc_bits); end
        run_instr(4'hB, 8'h00, 2'd2, b, m);
        total++; if (acc_bits !== 8'h78) begin bad++; $display("FAIL addr_acc got=%h want=78", acc_bits); end
        total++; if (flag_c !== 1'b0) begin bad++; $display("FAIL addr_c got=%b want=0", flag_c); end
        total++; if (flag_z !== 1'b0) begin bad++; $display("FAIL addr_z got=%b want=0", flag_z); end
    endtask

    task automatic test_shift_cmp();
        int b; logic [7:0] m;
        run_instr(4'h1, 8'h81, 2'd0, b, m);
        run_instr(4'h7, 8'h00, 2'd0, b, m);
        total++; if (acc_bits !== 8'h02) begin bad++; $display("FAIL shl_acc got=%h want=02", acc_bits); end
        total++; if (flag_c !== 1'b1) begin bad++; $display("FAIL shl_c got=%b want=1", flag_c); end
        run_instr(4'h8, 8'h00, 2'd0, b, m);
        total++; if (acc_bits !== 8'h01) begin bad++; $display("FAIL shr_acc got=%h want=01", acc_bits); end
        total++; if (flag_c !== 1'b0) begin bad++; $display("FAIL shr_c got=%b want=0", flag_c); end
        run_instr(4'hC, 8'h01, 2'd0, b, m);
        total++; if (acc_bits !== 8'h01) begin bad++; $display("FAIL cmp_acc got=%h want=01", acc_bits); end
        total++; if (flag_z !== 1'b1) begin bad++; $display("FAIL cmp_z got=%b want=1", flag_z); end
        total++; if (flag_c !== 1'b1) begin bad++; $display("FAIL cmp_c got=%b want=1", flag_c); end
    endtask

    task automatic test_logic();
        int b; logic [7:0] m;
        run_instr(4'h1, 8'hF0, 2'd0, b, m);
        run_instr(4'h4, 8'h3C, 2'd0, b, m);
        total++; if (acc_bits !== 8'h30) begin bad++; $display("FAIL and_acc got=%h want=30", acc_bits); end
        total++; if (flag_c !== 1'b0) begin bad++; $display("FAIL and_c got=%b want=0", flag_c); end
        total++; if (flag_z !== 1'b0) begin bad++; $display("FAIL and_z got=%b want=0", flag_z); end
        run_instr(4'h5, 8'h0F, 2'd0, b, m);
        total++; if (acc_bits !== 8'h3F) begin bad++; $display("FAIL or_acc got=%h want=3f", acc_bits); end
        run_instr(4'h6, 8'h3F, 2'd0, b, m);
        total++; if (acc_bits !== 8'h00) begin bad++; $display("FAIL xor_acc got=%h want=00", acc_bits); end
        total++; if (flag_z !== 1'b1) begin bad++; $display("FAIL xor_z got=%b want=1", flag_z); end
    endtask

    task automatic test_nop();
        int b; logic [7:0] m;
        run_instr(4'h1, 8'hA5, 2'd0, b, m);
        total++; if (flag_z !== 1'b1) begin bad++; $display("FAIL ldi_keeps_z got=%b want=1", flag_z); end
        run_instr(4'h0, 8'hFF, 2'd1, b, m);
        total++; if (acc_bits !== 8'hA5) begin bad++; $display("FAIL nop_acc got=%h want=a5", acc_bits); end
        total++; if (b != 9) begin bad++; $display("FAIL nop_busy_cycles got=%0d want=9", b); end
        run_instr(4'hE, 8'h12, 2'd3, b, m);
        total++; if (acc_bits !== 8'hA5) begin bad++; $display("FAIL op_e_acc got=%h want=a5", acc_bits); end
        total++; if (flag_z !== 1'b1 || flag_c !== 1'b0) begin
            bad++; $display("FAIL op_e_flags got=z%b c%b want=z1 c0", flag_z, flag_c);
        end
        total++; if (b != 9) begin bad++; $display("FAIL op_e_busy_cycles got=%0d want=9", b); end
    endtask

    task automatic test_back_to_back();
        int idle_at;
        @(negedge clk);
        opcode = 4'h1; instr = 12'h011; inst_done = 1'b1;
        @(negedge clk);
        inst_done = 1'b0;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_first_busy got=%b want=1", busy); end
        repeat (2) @(negedge clk);
        opcode = 4'h1; instr = 12'h022; inst_done = 1'b1;
        @(negedge clk);
        inst_done = 1'b0;
        idle_at = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin idle_at = i; break; end
        end
        total++; if (idle_at < 0) begin bad++; $display("FAIL b2b_timeout got=busy want=idle"); end
        repeat (4) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_queue got=%b want=0", busy); end
        total++; if (acc_bits !== 8'h11) begin bad++; $display("FAIL b2b_acc got=%h want=11", acc_bits); end
    endtask

    task automatic test_reset_mid();
        int b; logic [7:0] m;
        run_instr(4'h1, 8'h5A, 2'd0, b, m);
        @(negedge clk);
        opcode = 4'h2; instr = 12'h001; inst_done = 1'b1;
        @(negedge clk);
        inst_done = 1'b0;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (acc_bits !== 8'h00) begin bad++; $display("FAIL midrst_acc got=%h want=00", acc_bits); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (flag_z !== 1'b0) begin bad++; $display("FAIL midrst_z got=%b want=0", flag_z); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_no_start got=%b want=0", busy); end
        total++; if (acc_bits !== 8'h00) begin bad++; $display("FAIL midrst_no_commit got=%h want=00", acc_bits); end
        run_instr(4'hA, 8'h00, 2'd2, b, m);
        total++; if (acc_bits !== 8'h00) begin bad++; $display("FAIL midrst_reg_clear got=%h want=00", acc_bits); end
        total++; if (b != 9) begin bad++; $display("FAIL midrst_busy_cycles got=%0d want=9", b); end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_add_sub();
        test_regs();
        test_shift_cmp();
        test_logic();
        test_nop();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
